game_round_ctrl: RTL and testbench

- Round sequencer for the three-LED reaction game.
- Takes a player "go" button and drives the LED/score datapath:
  - `start` is held high for one timed round.
  - `change` pulses periodically so the datapath relights a random LED.
- Counts down round time and keeps a session high score from the datapath's score.
- Sits between the debounced button/display logic and the LED/score block.

---
 rtl/game_pkg.sv | 7 +
 rtl/game_tick_gen.sv | 38 +++
 rtl/game_round_ctrl.sv | 70 +++++++
 tb/tb_game_round_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared phase encoding and widths for the reaction-game round sequencer
package game_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, PLAY = 2'd2, DONE = 2'd3} phase_t;
  localparam int SCORE_W = 7;
  localparam int TIME_W = 6;
  localparam int SETTLE_CYC = 2;
endpackage

// File: rtl/game_tick_gen.sv
// game_tick_gen: one-second and LED-change prescaler with clear and fast-pace select
module game_tick_gen #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int CHANGE_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic fast,
  output logic sec_tick,
  output logic chg_tick
);
  localparam int W = $clog2(TICKS_PER_SEC);
  localparam int P = TICKS_PER_SEC / CHANGE_DIV;
  localparam int PF = (P / 2 < 1) ? 1 : P / 2;
  localparam logic [W-1:0] SEC_MAX = W'(TICKS_PER_SEC - 1);
  localparam logic [W-1:0] P_MAX = W'(P - 1);
  localparam logic [W-1:0] PF_MAX = W'(PF - 1);
  logic [W-1:0] sc, cc;
  logic fast_q;
  assign sec_tick = sc == SEC_MAX;
  assign chg_tick = cc == (fast_q ? PF_MAX : P_MAX);
  // pace is latched only at a change-period boundary so a period is never cut short
  always_ff @(posedge clk)
    if (!rst) begin
      sc <= '0;
      cc <= '0;
      fast_q <= 1'b0;
    end else if (clr) begin
      sc <= '0;
      cc <= '0;
      fast_q <= fast;
    end else begin
      sc <= sec_tick ? '0 : sc + 1'b1;
      cc <= chg_tick ? '0 : cc + 1'b1;
      if (chg_tick) fast_q <= fast;
    end
endmodule

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: arm/play/done round sequencer with session high score
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int CHANGE_DIV = 2,
  parameter int FAST_SCORE = 20,
  parameter int ROUND_SEC = 30,
  parameter int ARM_SEC = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [SCORE_W-1:0] score_in,
  output logic               start,
  output logic               change,
  output logic [TIME_W-1:0]  time_left,
  output logic [1:0]         phase,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_record,
  output logic               game_over
);
  phase_t state, nxt;
  logic go_q, go_rise, sec_tick, chg_tick, clr, fast, last_sec, settled;
  logic [1:0] st;
  assign go_rise = go & ~go_q;
  assign fast = score_in >= SCORE_W'(FAST_SCORE);
  assign last_sec = sec_tick && time_left == TIME_W'(1);
  assign settled = st > 2'(SETTLE_CYC);
  assign clr = nxt != state;
  assign phase = state;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = go_rise ? ARM : IDLE;
      ARM:  nxt = last_sec ? PLAY : ARM;
      PLAY: nxt = last_sec ? DONE : PLAY;
      DONE: nxt = (go_rise && settled) ? ARM : DONE;
    endcase
  end
  game_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC), .CHANGE_DIV(CHANGE_DIV)) u_tick (
    .clk(clk), .rst(rst), .clr(clr), .fast(fast), .sec_tick(sec_tick), .chg_tick(chg_tick)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      go_q <= 1'b1;
      st <= '0;
      time_left <= '0;
      start <= 1'b0;
      change <= 1'b0;
      game_over <= 1'b0;
      high_score <= '0;
      new_record <= 1'b0;
    end else begin
      go_q <= go;
      state <= nxt;
      start <= nxt == PLAY;
      change <= nxt == PLAY && (clr || chg_tick);
      game_over <= nxt == DONE && clr;
      st <= clr ? '0 : settled ? st : st + 1'b1;
      time_left <= clr ? (nxt == ARM ? TIME_W'(ARM_SEC) : nxt == PLAY ? TIME_W'(ROUND_SEC) : '0)
                       : (sec_tick && time_left != '0) ? time_left - 1'b1 : time_left;
      // score is stable by now: the datapath has seen start low for two cycles
      if (state == DONE && st == 2'(SETTLE_CYC)) begin
        new_record <= score_in > high_score;
        high_score <= score_in > high_score ? score_in : high_score;
      end
    end
endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: vector table, directed rounds and random stimulus against a cycle-count model
module tb_game_round_ctrl;
  localparam int T = 10, CD = 2, FS = 5, RS = 3, AS = 2;
  logic clk, rst, go;
  logic [6:0] score_in;
  logic start, change, new_record, game_over;
  logic [5:0] time_left;
  logic [1:0] phase;
  logic [6:0] high_score;
  int checks = 0, failures = 0;
  int m_ph, m_k, m_hs, m_seg;
  bit m_goq, m_nr, m_chg;

  game_round_ctrl #(.TICKS_PER_SEC(T), .CHANGE_DIV(CD), .FAST_SCORE(FS), .ROUND_SEC(RS), .ARM_SEC(AS)) dut (
    .clk(clk), .rst(rst), .go(go), .score_in(score_in), .start(start), .change(change),
    .time_left(time_left), .phase(phase), .high_score(high_score), .new_record(new_record),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int plen(input int s);
    return s >= FS ? (((T / CD) / 2 > 0) ? (T / CD) / 2 : 1) : T / CD;
  endfunction

  // model tracks phase and the cycle index within it; outputs follow by arithmetic
  task automatic model_edge();
    bit rise, wrap;
    int nph;
    if (!rst) begin
      m_ph = 0; m_k = 0; m_goq = 1; m_hs = 0; m_nr = 0; m_chg = 0; m_seg = 0;
      return;
    end
    rise = go && !m_goq;
    m_goq = go;
    nph = m_ph;
    if (m_ph == 0 && rise) nph = 1;
    if (m_ph == 1 && m_k == AS * T - 1) nph = 2;
    if (m_ph == 2 && m_k == RS * T - 1) nph = 3;
    if (m_ph == 3) begin
      if (m_k == 2) begin
        m_nr = int'(score_in) > m_hs;
        if (m_nr) m_hs = int'(score_in);
      end
      if (m_k >= 3 && rise) nph = 1;
    end
    wrap = m_ph == 2 && m_k == m_seg;
    if (nph != m_ph) begin
      m_ph = nph; m_k = 0; m_chg = nph == 2; m_seg = plen(int'(score_in)) - 1;
    end else begin
      if (wrap) m_seg = m_k + plen(int'(score_in));
      m_k++;
      m_chg = wrap;
    end
  endtask

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("phase", phase, m_ph);
    check("start", start, m_ph == 2);
    check("change", change, m_chg);
    check("time_left", time_left, m_ph == 1 ? AS - m_k / T : m_ph == 2 ? RS - m_k / T : 0);
    check("game_over", game_over, m_ph == 3 && m_k == 0);
    check("high_score", high_score, m_hs);
    check("new_record", new_record, m_nr);
  endtask

  // starts on ARM cycle 0, ends on the ARM cycle 0 of the following round
  task automatic round(input bit fast, input int dsc, input int hs, input int nr, input logic [63:0] exp_mask);
    int n;
    logic [63:0] m;
    n = 1;
    score_in = 0;
    for (int i = 0; i < 100 && phase == 1; i++) begin
      go = i == 3;
      tick();
      if (phase == 1) n++;
    end
    go = 0;
    check("arm_len", n, AS * T);
    check("play_tl0", time_left, RS);
    check("play_start0", start, 1);
    n = 0;
    m = '0;
    for (int i = 0; i < 100 && phase == 2; i++) begin
      if (change && n < 64) m[n] = 1'b1;
      go = n == 7;
      if (fast) score_in = (n >= 3 && n < 15) ? 7'd6 : (n >= 15 ? 7'd4 : 7'd0);
      tick();
      n++;
    end
    go = 0;
    score_in = 7'(dsc);
    check("play_len", n, RS * T);
    check("chg_mask", m, exp_mask);
    check("done_game_over", game_over, 1);
    check("done_start", start, 0);
    tick();
    go = 1;
    tick();
    check("done_go_early", phase, 3);
    go = 0;
    tick();
    check("hs", high_score, hs);
    check("nr", new_record, nr);
    go = 1;
    tick();
    check("done_go_late", phase, 1);
    check("rearm_tl", time_left, AS);
    go = 0;
  endtask

  typedef struct { logic r; logic g; int ph; int st; int tl; } vec_t;
  vec_t tbl[6];
  int norm_pos[6] = '{0, 5, 10, 15, 20, 25};
  int fast_pos[10] = '{0, 5, 7, 9, 11, 13, 15, 17, 22, 27};

  initial begin
    logic [63:0] m_norm, m_fast;
    int n;
    rst = 0; go = 1; score_in = 0;
    m_ph = 0; m_k = 0; m_goq = 1; m_hs = 0; m_nr = 0; m_chg = 0; m_seg = 0;
    m_norm = '0;
    m_fast = '0;
    foreach (norm_pos[i]) m_norm[norm_pos[i]] = 1'b1;
    foreach (fast_pos[i]) m_fast[fast_pos[i]] = 1'b1;
    tbl[0] = '{1'b0, 1'b1, 0, 0, 0};
    tbl[1] = '{1'b0, 1'b1, 0, 0, 0};
    tbl[2] = '{1'b1, 1'b1, 0, 0, 0};
    tbl[3] = '{1'b1, 1'b1, 0, 0, 0};
    tbl[4] = '{1'b1, 1'b0, 0, 0, 0};
    tbl[5] = '{1'b1, 1'b1, 1, 0, 2};
    for (int i = 0; i < 6; i++) begin
      rst = tbl[i].r;
      go = tbl[i].g;
      tick();
      check("vec_phase", phase, tbl[i].ph);
      check("vec_start", start, tbl[i].st);
      check("vec_tl", time_left, tbl[i].tl);
    end
    go = 0;
    round(1'b0, 9, 9, 1, m_norm);
    round(1'b1, 9, 9, 0, m_fast);
    round(1'b0, 12, 12, 1, m_norm);
    score_in = 0;
    for (int i = 0; i < 100 && phase != 2; i++) tick();
    for (int i = 0; i < 12; i++) tick();
    rst = 0;
    tick();
    check("mid_rst_start", start, 0);
    check("mid_rst_phase", phase, 0);
    check("mid_rst_hs", high_score, 0);
    check("mid_rst_tl", time_left, 0);
    rst = 1;
    n = 0;
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 599) != 0;
      go = $urandom_range(0, 5) == 0;
      score_in = 7'($urandom_range(0, 127));
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
